// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and types for the NTT butterfly sequencer.
//   N_LOG        log2 of polynomial length (one layer per bit)
//   NUM_BF       butterflies issued per layer
//   PIPE_LAT     default read-to-write-back latency (RAM read + BFU)
//   IDLE..DONE   sequencer state encoding
//   wb_entry_t   one slot of the write-back delay line
package ntt_pkg;

  localparam int unsigned N_LOG       = 8;
  localparam int unsigned NUM_LAYERS  = N_LOG;
  localparam int unsigned NUM_BF      = 1 << (N_LOG - 1);
  localparam int unsigned RD_LAT_DEF  = 1;
  localparam int unsigned BFU_LAT_DEF = 11;
  localparam int unsigned PIPE_LAT    = RD_LAT_DEF + BFU_LAT_DEF;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
  } wb_entry_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: maps (sel, layer, bf) to coefficient and twiddle addresses, registered.
//   clk, rst      clock, async active-high reset
//   sel           0: NTT (len halves per layer), 1: INTT (len doubles per layer)
//   layer, bf     layer 0..7 and butterfly index 0..127 for the next issue cycle
//   rd_addr_a/b   coefficient pair j, j+len
//   tw_addr       twiddle ROM index 1..255
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic [2:0] layer,
  input  logic [6:0] bf,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] tw_addr
);

  logic [2:0] s;
  logic [3:0] sh;
  logic [7:0] len;
  logic [6:0] g;
  logic [6:0] off;
  logic [7:0] a_d;
  logic [7:0] b_d;
  logic [7:0] tw_d;

  always_comb begin
    s   = sel ? layer : 3'd7 - layer;
    sh  = {1'b0, s} + 4'd1;
    len = 8'd1 << s;
    // bf splits into group index (high bits) and offset within the group (low s bits)
    g   = bf >> s;
    off = bf & 7'(len - 8'd1);
    a_d = ({1'b0, g} << sh) | {1'b0, off};
    b_d = a_d + len;
    // NTT walks zetas upward from 128>>s; INTT walks down from (256>>s)-1 == 255>>s
    if (sel) tw_d = (8'hFF >> s) - {1'b0, g};
    else     tw_d = (8'd128 >> s) + {1'b0, g};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      rd_addr_a <= a_d;
      rd_addr_b <= b_d;
      tw_addr   <= tw_d;
    end
  end

endmodule

// File: rtl/ntt_bfu_ctrl.sv
// ntt_bfu_ctrl: sequencer for one in-place 256-point NTT/INTT on a single butterfly unit.
//   clk, rst             clock, async active-high reset
//   start, sel           start request (IDLE only) and mode (0 NTT, 1 INTT)
//   busy, done           transform in progress / one-cycle completion pulse
//   bfu_sel              mode latched for the BFU
//   rd_en, rd_addr_a/b   read strobe and coefficient pair
//   tw_addr              twiddle ROM index
//   wr_en, wr_addr_a/b   delayed write-back strobe and destinations
//   layer                current layer 0..7
module ntt_bfu_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned RD_LAT  = RD_LAT_DEF,
  parameter int unsigned BFU_LAT = BFU_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  output logic       busy,
  output logic       done,
  output logic       bfu_sel,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic [2:0] layer
);

  localparam int unsigned WB_LAT     = RD_LAT + BFU_LAT;
  localparam int unsigned CNT_W      = $clog2(WB_LAT + 1);
  localparam logic [6:0]  LAST_BF    = 7'(NUM_BF - 1);
  localparam logic [2:0]  LAST_LAYER = 3'(NUM_LAYERS - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [6:0]       bf_q, bf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             rd_en_q;
  wb_entry_t        dly_q [WB_LAT];

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bf_d    = bf_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          sel_d   = sel;
          layer_d = '0;
          bf_d    = '0;
        end
      end
      ISSUE: begin
        bf_d = bf_q + 7'd1;
        if (bf_q == LAST_BF) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(1);
        end
      end
      DRAIN: begin
        // Hold off the next layer until its inputs have all been written back
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WB_LAT)) begin
          if (layer_q == LAST_LAYER) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            layer_d = layer_q + 3'd1;
            bf_d    = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      bf_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bf_q    <= bf_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rd_en_q <= (state_d == ISSUE);
    end
  end

  // Fed with next-state values so the registered addresses line up with rd_en_q
  ntt_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel_d),
    .layer     (layer_d),
    .bf        (bf_d),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr)
  );

  // Slot 0 captures the issue cycle, so the last slot appears WB_LAT cycles after rd_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WB_LAT); i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= '{vld: rd_en_q, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < int'(WB_LAT); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign bfu_sel   = sel_q;
  assign rd_en     = rd_en_q;
  assign layer     = layer_q;
  assign wr_en     = dly_q[WB_LAT-1].vld;
  assign wr_addr_a = dly_q[WB_LAT-1].a;
  assign wr_addr_b = dly_q[WB_LAT-1].b;

endmodule

// File: tb/tb_ntt_bfu_ctrl.sv
module tb_ntt_bfu_ctrl;

  localparam int MAXC  = 1130;
  localparam int PIPE  = 12;
  localparam int SPAN  = 140;
  localparam int LASTC = 1124;

  logic       clk, rst, start, sel;
  logic       busy, done, bfu_sel, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic [2:0] layer;

  ntt_bfu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .bfu_sel   (bfu_sel),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .layer     (layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour per cycle after the start edge
  int e_rd [MAXC];
  int e_wr [MAXC];
  int e_busy [MAXC];
  int e_done [MAXC];
  int e_a [MAXC];
  int e_b [MAXC];
  int e_tw [MAXC];
  int e_wa [MAXC];
  int e_wb [MAXC];
  int e_layer [MAXC];

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  bit rst_chk = 1'b0;
  logic cur_sel = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Classic loop-nest form of the transform: zeta index k walks up (NTT) or down (INTT)
  task automatic build(input logic s);
    int c, k, len;
    cur_sel = s;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_a[i] = 0;
      e_b[i] = 0; e_tw[i] = 0; e_wa[i] = 0; e_wb[i] = 0; e_layer[i] = 0;
    end
    k = s ? 256 : 0;
    for (int l = 0; l < 8; l++) begin
      len = s ? (1 << l) : (128 >> l);
      c = 1 + SPAN * l;
      for (int st = 0; st < 256; st += 2 * len) begin
        k = s ? k - 1 : k + 1;
        for (int j = st; j < st + len; j++) begin
          e_rd[c] = 1; e_a[c] = j; e_b[c] = j + len; e_tw[c] = k;
          e_wr[c+PIPE] = 1; e_wa[c+PIPE] = j; e_wb[c+PIPE] = j + len;
          c++;
        end
      end
      for (int x = 1 + SPAN * l; x <= SPAN + SPAN * l; x++) e_layer[x] = l;
    end
    for (int x = 1; x <= 1120; x++) e_busy[x] = 1;
    e_done[1121] = 1;
  endtask

  task automatic pin_model();
    if (!cur_sel) begin
      chk("pin_ntt_c1_a", e_a[1], 0);      chk("pin_ntt_c1_b", e_b[1], 128);
      chk("pin_ntt_c1_tw", e_tw[1], 1);    chk("pin_ntt_c128_a", e_a[128], 127);
      chk("pin_ntt_c128_b", e_b[128], 255); chk("pin_ntt_c128_tw", e_tw[128], 1);
      chk("pin_ntt_c981_b", e_b[981], 1);  chk("pin_ntt_c981_tw", e_tw[981], 128);
      chk("pin_ntt_c1108_a", e_a[1108], 254); chk("pin_ntt_c1108_tw", e_tw[1108], 255);
      chk("pin_last_wr", e_wr[1120], 1);   chk("pin_done", e_done[1121], 1);
      chk("pin_busy_off", e_busy[1121], 0); chk("pin_rd_l1", e_rd[141], 1);
      chk("pin_rd_drain", e_rd[140], 0);
    end else begin
      chk("pin_intt_c1_b", e_b[1], 1);     chk("pin_intt_c1_tw", e_tw[1], 255);
      chk("pin_intt_c2_a", e_a[2], 2);     chk("pin_intt_c2_b", e_b[2], 3);
      chk("pin_intt_c2_tw", e_tw[2], 254); chk("pin_intt_c981_b", e_b[981], 128);
      chk("pin_intt_c981_tw", e_tw[981], 1);
    end
  endtask

  // Single compare process, samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_chk) begin
        chk("rst_busy", int'(busy), 0);       chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);     chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_bfu_sel", int'(bfu_sel), 0); chk("rst_layer", int'(layer), 0);
        chk("rst_rd_a", int'(rd_addr_a), 0);  chk("rst_tw", int'(tw_addr), 0);
        chk("rst_wr_a", int'(wr_addr_a), 0);
      end else if (chk_on) begin
        cyc = cyc + 1;
        if (cyc == 1) begin
          n_done = 0;
          pin_model();
        end
        chk("busy", int'(busy), e_busy[cyc]);
        chk("done", int'(done), e_done[cyc]);
        chk("rd_en", int'(rd_en), e_rd[cyc]);
        chk("wr_en", int'(wr_en), e_wr[cyc]);
        if (e_rd[cyc] != 0) begin
          chk("rd_addr_a", int'(rd_addr_a), e_a[cyc]);
          chk("rd_addr_b", int'(rd_addr_b), e_b[cyc]);
          chk("tw_addr", int'(tw_addr), e_tw[cyc]);
        end
        if (e_wr[cyc] != 0) begin
          chk("wr_addr_a", int'(wr_addr_a), e_wa[cyc]);
          chk("wr_addr_b", int'(wr_addr_b), e_wb[cyc]);
        end
        if (e_busy[cyc] != 0) begin
          chk("bfu_sel", int'(bfu_sel), int'(cur_sel));
          chk("layer", int'(layer), e_layer[cyc]);
        end
        if (done) n_done++;
        if (cyc == LASTC) chk("done_pulses", n_done, 1);
      end else begin
        cyc = 0;
      end
    end
  end

  task automatic run(input logic s, input bit repulse, input int abort_at);
    int cur;
    build(s);
    @(posedge clk); #1;
    start = 1'b1; sel = s;
    @(posedge clk); #1;
    start = 1'b0; chk_on = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      if (cyc + 1 >= LASTC + 1) break;
      @(posedge clk); #1;
      cur = cyc + 1;
      if (abort_at != 0 && cur == abort_at) begin
        chk_on = 1'b0;
        #2;
        rst = 1'b1;
        rst_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_chk = 1'b0;
        start = 1'b0;
        return;
      end
      // Start pulses inside the transform and in the DONE cycle must be ignored
      if (repulse && (cur == 300 || cur == 1120 || cur == 1121)) begin
        start = 1'b1; sel = ~s;
      end else begin
        start = 1'b0;
      end
    end
    chk_on = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    rst_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_chk = 1'b0;
    repeat (2) @(posedge clk);
    run(1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    run(1'b1, 1'b0, 0);
    repeat (3) @(posedge clk);
    run(1'b0, 1'b0, 500);
    repeat (2) @(posedge clk);
    run(1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    run(1'b1, 1'b1, 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
